// File: rtl/fetch_ir_if.sv
// Instruction-memory read channel between the fetch/IR stage (master) and memory (slave).
interface fetch_ir_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/fetch_ir_unit.sv
// Multicycle MIPS fetch / instruction-register stage: PC register, instruction-memory
// read handshake with timeout, IR latch and field decode.
//
// state  | meaning
// S_IDLE | no fetch outstanding; ir_write launches a read at the current pc
// S_WAIT | read outstanding; waiting for mem_ack or timeout, stall asserted
module fetch_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  fetch_ir_if.master        mem,
  input  logic              i_ir_write,
  input  logic              i_pc_write,
  input  logic              i_pc_write_cond,
  input  logic [1:0]        i_pc_src,
  input  logic              i_alu_zero,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_alu_out,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_ir,
  output logic [5:0]        o_opcode,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [5:0]        o_funct,
  output logic [15:0]       o_imm16,
  output logic              o_ir_valid,
  output logic              o_stall,
  output logic              o_bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mem_addr;
  logic        r_mem_req;
  logic        r_ir_valid;
  logic        r_bus_err;

  logic        w_load;
  logic [31:0] w_pc_next;

  assign w_load = i_pc_write | (i_pc_write_cond & i_alu_zero);

  // Jump target is built from the IR as registered now, not the value arriving this cycle.
  always_comb begin
    w_pc_next = r_pc;
    case (i_pc_src)
      2'd0:    w_pc_next = i_alu_result;
      2'd1:    w_pc_next = i_alu_out;
      2'd2:    w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_load) begin
      r_pc <= w_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_ir       <= 32'd0;
      r_mem_addr <= 32'd0;
      r_mem_req  <= 1'b0;
      r_ir_valid <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_ir_write) begin
            r_mem_addr <= r_pc;
            r_mem_req  <= 1'b1;
            r_cnt      <= 8'd0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (mem.mem_ack) begin
            r_ir       <= mem.mem_rdata;
            r_ir_valid <= 1'b1;
            r_mem_req  <= 1'b0;
            r_state    <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_ir      <= 32'd0;
            r_bus_err <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_mem_addr;

  assign o_pc       = r_pc;
  assign o_ir       = r_ir;
  assign o_opcode   = r_ir[31:26];
  assign o_rs       = r_ir[25:21];
  assign o_rt       = r_ir[20:16];
  assign o_rd       = r_ir[15:11];
  assign o_funct    = r_ir[5:0];
  assign o_imm16    = r_ir[15:0];
  assign o_ir_valid = r_ir_valid;
  assign o_stall    = (r_state == S_WAIT);
  assign o_bus_err  = r_bus_err;

endmodule
